// File: rtl/joystick_input.sv
// Joystick front end for the snake game: synchronizes and debounces four raw
// contacts, turns presses into a pending turn, and commits it on step_tick.
module joystick_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       joy_up,
  input  logic       joy_right,
  input  logic       joy_down,
  input  logic       joy_left,
  input  logic       step_tick,
  output logic [1:0] direction,
  output logic       turn_pulse,
  output logic       pending_valid
);

  typedef enum logic [1:0] {
    TOP_DIR    = 2'd0,
    RIGHT_DIR  = 2'd1,
    BOTTOM_DIR = 2'd2,
    LEFT_DIR   = 2'd3
  } dir_t;

  localparam logic [19:0] DEB_LIMIT = 20'(DEBOUNCE_CYCLES);

  logic [3:0]  raw_lines;
  logic [3:0]  sync_1;
  logic [3:0]  sync_2;
  logic [3:0]  pressed_sync;
  logic [3:0]  debounced;
  logic [3:0]  press_evt;
  logic [19:0] deb_count [4];

  dir_t dir_q;
  dir_t pending_dir;
  dir_t press_dir;
  dir_t cand_dir;
  logic press_any;
  logic cand_valid;
  logic cand_legal;

  // Bit index matches the direction encoding, so bit 0 is up and bit 3 is left.
  assign raw_lines    = {joy_left, joy_down, joy_right, joy_up};
  assign pressed_sync = ACTIVE_LOW ? ~sync_2 : sync_2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= {4{ACTIVE_LOW}};
      sync_2 <= {4{ACTIVE_LOW}};
    end else begin
      sync_1 <= raw_lines;
      sync_2 <= sync_1;
    end
  end

  // press_evt is a one-cycle pulse on the debounced released->pressed flip.
  always_ff @(posedge clk) begin
    if (reset) begin
      debounced <= '0;
      press_evt <= '0;
      for (int i = 0; i < 4; i++) deb_count[i] <= '0;
    end else begin
      press_evt <= '0;
      for (int i = 0; i < 4; i++) begin
        if (pressed_sync[i] == debounced[i]) begin
          deb_count[i] <= '0;
        end else if (deb_count[i] == DEB_LIMIT) begin
          debounced[i]    <= pressed_sync[i];
          press_evt[i]    <= pressed_sync[i];
          deb_count[i]    <= '0;
        end else begin
          deb_count[i] <= deb_count[i] + 20'd1;
        end
      end
    end
  end

  always_comb begin
    press_any = |press_evt;
    press_dir = TOP_DIR;
    if (press_evt[0])      press_dir = TOP_DIR;
    else if (press_evt[1]) press_dir = RIGHT_DIR;
    else if (press_evt[2]) press_dir = BOTTOM_DIR;
    else if (press_evt[3]) press_dir = LEFT_DIR;

    cand_valid = press_any | pending_valid;
    cand_dir   = press_any ? press_dir : pending_dir;
    // Reversal is judged against the direction held right now, at commit time.
    cand_legal = cand_valid && (cand_dir != dir_q) && (cand_dir != (dir_q ^ 2'b10));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q         <= TOP_DIR;
      pending_dir   <= TOP_DIR;
      pending_valid <= 1'b0;
      turn_pulse    <= 1'b0;
    end else begin
      turn_pulse <= 1'b0;
      if (step_tick) begin
        pending_valid <= 1'b0;
        if (cand_legal) begin
          dir_q      <= cand_dir;
          turn_pulse <= 1'b1;
        end
      end else if (press_any) begin
        pending_dir   <= press_dir;
        pending_valid <= 1'b1;
      end
    end
  end

  assign direction = dir_q;

endmodule

// File: tb/tb_joystick_input.sv
// Directed bench for joystick_input with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1:
// a vector table of press/tick scenarios plus hand sequences for timing corners.
module tb_joystick_input;

  localparam logic [3:0] M_UP    = 4'b0001;
  localparam logic [3:0] M_RIGHT = 4'b0010;
  localparam logic [3:0] M_DOWN  = 4'b0100;
  localparam logic [3:0] M_LEFT  = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       joy_up, joy_right, joy_down, joy_left;
  logic       step_tick;
  logic [1:0] direction;
  logic       turn_pulse;
  logic       pending_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] mask;
    logic [1:0] exp_dir;
    logic       exp_turn;
  } vec_t;

  vec_t vecs [10];

  joystick_input #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .joy_up       (joy_up),
    .joy_right    (joy_right),
    .joy_down     (joy_down),
    .joy_left     (joy_left),
    .step_tick    (step_tick),
    .direction    (direction),
    .turn_pulse   (turn_pulse),
    .pending_valid(pending_valid)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setRaw(input logic [3:0] mask);
    joy_up    = ~mask[0];
    joy_right = ~mask[1];
    joy_down  = ~mask[2];
    joy_left  = ~mask[3];
  endtask

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [1:0] exp_dir,
                             input logic exp_turn, input logic exp_pend);
    checkVal({name, ".direction"}, int'(direction), int'(exp_dir));
    checkVal({name, ".turn_pulse"}, int'(turn_pulse), int'(exp_turn));
    checkVal({name, ".pending_valid"}, int'(pending_valid), int'(exp_pend));
  endtask

  task automatic doReset();
    reset     = 1'b1;
    step_tick = 1'b0;
    setRaw(4'b0000);
    cycles(2);
    reset = 1'b0;
    cycles(1);
  endtask

  // Hold the lines long enough to debounce, then release and let the release settle.
  task automatic applyStimulus(input logic [3:0] mask);
    setRaw(mask);
    cycles(10);
    setRaw(4'b0000);
    cycles(10);
  endtask

  task automatic pulseTick();
    step_tick = 1'b1;
    cycles(1);
    step_tick = 1'b0;
  endtask

  initial begin
    vecs[0] = '{mask: M_RIGHT,          exp_dir: 2'd1, exp_turn: 1'b1};
    vecs[1] = '{mask: M_LEFT,           exp_dir: 2'd1, exp_turn: 1'b0};
    vecs[2] = '{mask: M_DOWN,           exp_dir: 2'd2, exp_turn: 1'b1};
    vecs[3] = '{mask: M_UP,             exp_dir: 2'd2, exp_turn: 1'b0};
    vecs[4] = '{mask: M_RIGHT | M_LEFT, exp_dir: 2'd1, exp_turn: 1'b1};
    vecs[5] = '{mask: M_UP | M_DOWN,    exp_dir: 2'd0, exp_turn: 1'b1};
    vecs[6] = '{mask: 4'b0000,          exp_dir: 2'd0, exp_turn: 1'b0};
    vecs[7] = '{mask: M_LEFT,           exp_dir: 2'd3, exp_turn: 1'b1};
    vecs[8] = '{mask: M_UP | M_RIGHT,   exp_dir: 2'd0, exp_turn: 1'b1};
    vecs[9] = '{mask: M_DOWN,           exp_dir: 2'd0, exp_turn: 1'b0};

    doReset();
    checkOutput("reset", 2'd0, 1'b0, 1'b0);

    // Press latency: event one cycle after the debounced flip at edge 7.
    setRaw(M_RIGHT);
    cycles(7);
    checkVal("latency.pend_edge7", int'(pending_valid), 0);
    cycles(1);
    checkVal("latency.pend_edge8", int'(pending_valid), 1);
    cycles(3);
    pulseTick();
    checkOutput("latency.tick", 2'd1, 1'b1, 1'b0);
    cycles(1);
    checkOutput("latency.after", 2'd1, 1'b0, 1'b0);
    cycles(8);
    setRaw(4'b0000);
    cycles(10);

    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].mask);
      checkVal($sformatf("vec%0d.pend", i), int'(pending_valid), int'(vecs[i].mask != 4'b0000));
      pulseTick();
      checkOutput($sformatf("vec%0d.tick", i), vecs[i].exp_dir, vecs[i].exp_turn, 1'b0);
      cycles(1);
      checkVal($sformatf("vec%0d.turn_off", i), int'(turn_pulse), 0);
    end

    // A 3-cycle glitch never reaches the debounce threshold.
    doReset();
    setRaw(M_LEFT);
    cycles(3);
    setRaw(4'b0000);
    cycles(12);
    checkVal("glitch.pend", int'(pending_valid), 0);
    pulseTick();
    checkOutput("glitch.tick", 2'd0, 1'b0, 1'b0);

    applyStimulus(M_RIGHT);
    applyStimulus(M_LEFT);
    checkVal("lastwins.pend", int'(pending_valid), 1);
    pulseTick();
    checkOutput("lastwins.tick", 2'd3, 1'b1, 1'b0);

    // Press event landing on the same cycle as step_tick is committed directly.
    cycles(1);
    setRaw(M_UP);
    cycles(7);
    step_tick = 1'b1;
    cycles(1);
    step_tick = 1'b0;
    checkOutput("sametick", 2'd0, 1'b1, 1'b0);
    cycles(1);
    checkVal("sametick.nopend", int'(pending_valid), 0);
    setRaw(4'b0000);
    cycles(10);

    // Reset wins over a legal pending turn and a simultaneous tick.
    applyStimulus(M_RIGHT);
    pulseTick();
    checkVal("pre_reset.dir", int'(direction), 1);
    applyStimulus(M_DOWN);
    checkVal("pre_reset.pend", int'(pending_valid), 1);
    reset     = 1'b1;
    step_tick = 1'b1;
    cycles(1);
    reset     = 1'b0;
    step_tick = 1'b0;
    checkOutput("reset_tick", 2'd0, 1'b0, 1'b0);

    // Reset mid-debounce discards counter progress.
    cycles(2);
    setRaw(M_RIGHT);
    cycles(4);
    reset = 1'b1;
    setRaw(4'b0000);
    cycles(1);
    reset = 1'b0;
    cycles(12);
    checkVal("mid_debounce.pend", int'(pending_valid), 0);
    pulseTick();
    checkOutput("mid_debounce.tick", 2'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
